nnvr_builder: RTL
=================

# nnvr_builder

Front-end scan stage for the voting convolution datapath. It reads the dense input feature map (IFM) once in raster order and writes the address of every non-zero value into the non-null value reference (NNVR) memory as a compacted list. It also reports the resulting count. The voting block downstream walks that list (NNVR address to IFM address) and uses the count as its number of non-null values.

## Interface
Parameters:
- FM_SIZE, `FM_SIZE: feature map side; the IFM holds FM_SIZE**2 values.
- DATA_WIDTH, `A_DSP_WIDTH: IFM value width (signed).
- RD_LATENCY, 1: IFM memory read latency in cycles; 1 means synchronous BRAM, legal range 1..4.

Ports (AW = $clog2(FM_SIZE**2)):
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start pulse; only sampled in IDLE or DONE.
- o_ifm_r_addr  out  AW+1  IFM read address; the extra bit marks end of scan.
- o_ifm_r_en  out  1  IFM read enable, high while an address is issued.
- i_data  in  DATA_WIDTH  signed IFM read data.
- o_nnvr_w_addr  out  AW+1  NNVR write address (list index).
- o_nnvr_w_data  out  AW  NNVR write data (raster address of a non-zero IFM value).
- o_nnvr_w_en  out  1  NNVR write strobe, one cycle per entry.
- o_values  out  AW+1  running, then final, count of non-zero values.
- o_busy  out  1  high in SCAN and DRAIN.
- o_done  out  1  sticky completion flag.

## Operation
- States:
  - IDLE: waits for i_start.
  - SCAN: issues read addresses.
  - DRAIN: waits for the read pipeline to empty.
  - DONE: holds results.
- Transitions:
  - IDLE→SCAN on i_start.
  - SCAN→DRAIN after address FM_SIZE**2-1 is issued.
  - DRAIN→DONE when the tag pipeline is empty.
  - DONE→SCAN on i_start (restart).
  - DONE otherwise holds.
- SCAN issues addresses 0..FM_SIZE**2-1, one per cycle, with o_ifm_r_en=1.
- Each issued address enters a tag pipeline of depth RD_LATENCY+1 (valid bit plus address), so each returned value is matched to its address.
- When a valid tag reaches the pipeline end, i_data is tested. If i_data != 0 (any sign), the block registers:
  - o_nnvr_w_en=1
  - o_nnvr_w_data=tag address
  - o_nnvr_w_addr=o_values
  - o_values=o_values+1
- Zero data produces no write. o_nnvr_w_en is low in all other cycles.
- At the last address issue, o_ifm_r_addr advances to FM_SIZE**2 and holds. o_ifm_r_en drops to 0.
- Entering SCAN, from IDLE or from DONE, clears o_values, o_done, o_nnvr_w_addr and the tag pipeline, and sets o_ifm_r_addr=0.
- i_start during SCAN or DRAIN is ignored.
- Count width AW+1 holds FM_SIZE**2 exactly (all-nonzero map) with no wrap.

## Timing
- Reset values: all outputs 0, state IDLE, tag pipeline invalid.
- Reset asserted mid-scan aborts immediately. No write strobe is seen after the reset edge.
- Let E0 be the edge that samples i_start. Then:
  - After E0: o_ifm_r_addr=0, o_ifm_r_en=1, o_busy=1.
  - After E0+k: o_ifm_r_addr=k, for k < FM_SIZE**2.
  - The write for address a, if non-zero, is visible after edge E0+a+RD_LATENCY+1.
  - The last possible write is visible after E0+FM_SIZE**2+RD_LATENCY.
  - After E0+FM_SIZE**2+RD_LATENCY+1: o_done=1 and o_busy=0. o_values is final and stable no later than o_done.
- Throughput is one IFM value per cycle, with no stalls.
- Write addresses are strictly sequential 0..o_values-1.

## Test plan
- 4x4 all-zero map, RD_LATENCY=1 -> no write strobes; o_values=0; o_done rises after E0+18.
- 4x4 map with non-zeros only at 0, 5 and 15 -> three writes: (addr0, data0) after E0+2, (addr1, data5) after E0+7, (addr2, data15) after E0+17; o_values=3; o_done after E0+18.
- 4x4 all-nonzero map including negatives (-1, -128) -> 16 writes, data 0..15 at addresses 0..15; o_values=16 with no overflow.
- RD_LATENCY=3, non-zero at address 0 only -> single write visible after E0+4; o_done after E0+20.
- Assert i_rst after E0+6 during a dense scan -> all outputs 0 immediately and state IDLE; a new i_start rescans from address 0 with o_values counting from 0.
- After DONE, pulse i_start with a different map (non-zero only at 9) -> o_done clears after the start edge; one write (addr0, data9); o_values=1; i_start pulsed mid-scan has no effect.

Source files
------------

// File: rtl/nnvr_builder.sv
// Raster scan of the dense IFM that emits a compacted list of the addresses of
// non-zero values into NNVR memory, together with the resulting count.
module nnvr_builder #(
  parameter int FM_SIZE    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  localparam int AW        = $clog2(FM_SIZE * FM_SIZE)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  output logic [AW:0]                  o_ifm_r_addr,
  output logic                         o_ifm_r_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic [AW:0]                  o_nnvr_w_addr,
  output logic [AW-1:0]                o_nnvr_w_data,
  output logic                         o_nnvr_w_en,
  output logic [AW:0]                  o_values,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int          NUM_VALUES = FM_SIZE * FM_SIZE;
  localparam logic [AW:0] LAST_ADDR  = (AW + 1)'(NUM_VALUES - 1);
  localparam logic [AW:0] ONE        = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [AW:0]             r_addr_q, r_addr_d;
  logic                    r_en_q, r_en_d;
  logic [RD_LATENCY-1:0]   tag_v_q, tag_v_d;
  logic [AW-1:0]           tag_a_q [RD_LATENCY];
  logic [AW-1:0]           tag_a_d [RD_LATENCY];
  logic [AW:0]             w_addr_q, w_addr_d;
  logic [AW-1:0]           w_data_q, w_data_d;
  logic                    w_en_q, w_en_d;
  logic [AW:0]             values_q, values_d;
  logic                    done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      r_addr_q <= '0;
      r_en_q   <= 1'b0;
      tag_v_q  <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_a_q[i] <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      values_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_addr_q <= r_addr_d;
      r_en_q   <= r_en_d;
      tag_v_q  <= tag_v_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_a_q[i] <= tag_a_d[i];
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      values_q <= values_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_addr_d = r_addr_q;
    r_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;
    values_d = values_q;
    done_d   = done_q;

    // The issued address register is tag stage 0; these are stages 1..RD_LATENCY,
    // so the last stage lines up with the data returned for that address.
    tag_v_d    = '0;
    tag_v_d[0] = r_en_q;
    for (int unsigned i = 0; i < RD_LATENCY; i++) tag_a_d[i] = '0;
    tag_a_d[0] = r_addr_q[AW-1:0];
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_a_d[i] = tag_a_q[i-1];
    end

    if (tag_v_q[RD_LATENCY-1] && (i_data != '0)) begin
      w_en_d   = 1'b1;
      w_data_d = tag_a_q[RD_LATENCY-1];
      w_addr_d = values_q;
      values_d = values_q + ONE;
    end

    case (state_q)
      S_SCAN: begin
        r_addr_d = r_addr_q + ONE;
        r_en_d   = (r_addr_q != LAST_ADDR);
        if (r_addr_q == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_v_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // Starting (from IDLE or DONE) overrides everything: the pipeline is
    // already empty there, so no pending write can be lost.
    if ((state_q == S_IDLE || state_q == S_DONE) && i_start) begin
      state_d  = S_SCAN;
      r_addr_d = '0;
      r_en_d   = 1'b1;
      tag_v_d  = '0;
      w_addr_d = '0;
      w_en_d   = 1'b0;
      values_d = '0;
      done_d   = 1'b0;
    end
  end

  assign o_ifm_r_addr  = r_addr_q;
  assign o_ifm_r_en    = r_en_q;
  assign o_nnvr_w_addr = w_addr_q;
  assign o_nnvr_w_data = w_data_q;
  assign o_nnvr_w_en   = w_en_q;
  assign o_values      = values_q;
  assign o_busy        = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign o_done        = done_q;

endmodule
